// File: rtl/timer_pkg.sv
// Shared definitions for the timer array: channel FSM encoding, register
// offsets within a channel window, CTRL field positions and MODE codes.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CNT    = 2'd2,
    ST_EXPIRE = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LO  = 1;
  localparam int CTRL_MODE_HI  = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PRESC_LO = 8;
  localparam int CTRL_PRESC_HI = 15;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Reassemble the CTRL register image; unimplemented bits read as zero.
  function automatic logic [31:0] pack_ctrl(input logic en, input logic [1:0] mode,
                                            input logic im, input logic [7:0] presc);
    return {16'h0000, presc, 4'h0, im, mode, en};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/preset registers, prescaler, down-counter,
// IDLE/LOAD/CNT/EXPIRE sequencing and the sticky pending flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [31:0]      wdata,
  output logic [31:0]      ctrl_rd,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pending,
  output logic             irq
);

  logic       en;
  logic       im;
  logic [1:0] mode;
  logic [7:0] presc;
  logic [7:0] presc_cnt;
  state_e     state;
  state_e     state_nxt;
  logic       load;
  logic       dec;
  logic       expire;
  logic       clr_en;
  logic       presc_clr;
  logic       presc_inc;
  logic       tick;
  logic       unused_wdata;

  // Bits that only matter for narrow presets or reserved CTRL fields.
  assign unused_wdata = ^{wdata[31:16], wdata[7:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    expire    = 1'b0;
    clr_en    = 1'b0;
    presc_clr = 1'b0;
    presc_inc = 1'b0;
    tick      = (presc_cnt == presc);
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
        else    state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          load      = 1'b1;
          state_nxt = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          presc_clr = 1'b1;
          // A preset of zero expires on the first tick just like a preset of one.
          if (count <= CNT_W'(1)) begin
            expire    = 1'b1;
            state_nxt = ST_EXPIRE;
          end else begin
            dec       = 1'b1;
            state_nxt = ST_CNT;
          end
        end else begin
          presc_inc = 1'b1;
          state_nxt = ST_CNT;
        end
      end
      ST_EXPIRE: begin
        if (mode == MODE_RELOAD) begin
          state_nxt = ST_LOAD;
        end else begin
          clr_en    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en        <= 1'b0;
      mode      <= 2'd0;
      im        <= 1'b0;
      presc     <= 8'd0;
      preset    <= '0;
      count     <= '0;
      presc_cnt <= 8'd0;
      pending   <= 1'b0;
    end else begin
      if (ctrl_we) begin
        en    <= wdata[CTRL_EN];
        mode  <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im    <= wdata[CTRL_IM];
        presc <= wdata[CTRL_PRESC_HI:CTRL_PRESC_LO];
      end else if (clr_en) begin
        en <= 1'b0;
      end
      if (preset_we) preset <= wdata[CNT_W-1:0];
      if (load)        count <= preset;
      else if (expire) count <= '0;
      else if (dec)    count <= count - CNT_W'(1);
      if (load || presc_clr) presc_cnt <= 8'd0;
      else if (presc_inc)    presc_cnt <= presc_cnt + 8'd1;
      // Expiry beats a simultaneous software clear so no event is lost.
      if (expire) pending <= 1'b1;
      else if (ctrl_we || (status_we && wdata[0])) pending <= 1'b0;
    end
  end

  assign ctrl_rd = pack_ctrl(en, mode, im, presc);
  assign irq     = pending & im;

endmodule

// File: rtl/timer_array.sv
// Array of independent timer channels behind a word-addressed register window,
// with a combinational read mux and per-channel plus combined interrupts.
module timer_array
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ,
  output logic              IRQ_any
);

  logic [27:0]      chan_idx;
  logic [1:0]       reg_sel;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pend;
  logic [31:0]      ctrl_rd   [NUM_CH];
  logic [CNT_W-1:0] preset_rd [NUM_CH];
  logic [CNT_W-1:0] count_rd  [NUM_CH];
  logic [31:0]      sel_ctrl;
  logic [31:0]      sel_preset;
  logic [31:0]      sel_count;
  logic             sel_pend;

  // The full upper address is the channel index, so out-of-range accesses never alias.
  assign chan_idx = Addr[29:2];
  assign reg_sel  = Addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i] = (chan_idx == 28'(i));
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (WE && hit[i] && (reg_sel == REG_CTRL)),
      .preset_we (WE && hit[i] && (reg_sel == REG_PRESET)),
      .status_we (WE && hit[i] && (reg_sel == REG_STATUS)),
      .wdata     (Din),
      .ctrl_rd   (ctrl_rd[i]),
      .preset    (preset_rd[i]),
      .count     (count_rd[i]),
      .pending   (pend[i]),
      .irq       (IRQ[i])
    );
  end

  // One-hot OR read mux; no hit leaves every field zero.
  always_comb begin
    sel_ctrl   = 32'd0;
    sel_preset = 32'd0;
    sel_count  = 32'd0;
    sel_pend   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_ctrl               = sel_ctrl | (hit[i] ? ctrl_rd[i] : 32'd0);
      sel_preset[CNT_W-1:0]  = sel_preset[CNT_W-1:0] | (hit[i] ? preset_rd[i] : '0);
      sel_count[CNT_W-1:0]   = sel_count[CNT_W-1:0] | (hit[i] ? count_rd[i] : '0);
      sel_pend               = sel_pend | (hit[i] & pend[i]);
    end
    case (reg_sel)
      REG_CTRL:   Dout = sel_ctrl;
      REG_PRESET: Dout = sel_preset;
      REG_COUNT:  Dout = sel_count;
      REG_STATUS: Dout = {31'd0, sel_pend};
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ_any = |IRQ;

endmodule
